// File: rtl/locked_cla_adder_pipe.sv
// Pipelined, XOR-key-locked carry-lookahead adder: one GROUP-bit carry slice per stage, serially loaded key.
// Define LOCKED_CLA_CIN_EN to add a carry-in port (cin); otherwise the carry into bit 0 is 0.
module locked_cla_adder_pipe #(
    parameter int unsigned       WIDTH   = 16,
    parameter int unsigned       GROUP   = 4,
    parameter int unsigned       KEY_W   = 32,
    parameter logic [KEY_W-1:0]  KEY_POL = 32'hA5C3_0F96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_shift,
    input  logic             key_sin,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
`ifdef LOCKED_CLA_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result_o
);

    localparam int unsigned STAGES = WIDTH / GROUP;
    localparam int unsigned CNT_W  = $clog2(KEY_W + 1);

    typedef enum logic {
        KEY_LOAD = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Operands travel whole; each stage overwrites its own group of sum bits and forwards the group carry.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } stage_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [CNT_W-1:0]  key_cnt_q, key_cnt_d;
    logic [STAGES-1:0] vld_q, vld_d;
    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];

    logic [KEY_W-1:0]  key_shifted;
    logic              flush;
    logic [WIDTH-1:0]  corrupt;
    logic [STAGES-1:0] adv;
    logic              take;
    logic              cin_bit;
    stage_t            src0;

`ifdef LOCKED_CLA_CIN_EN
    assign cin_bit = cin;
`else
    assign cin_bit = 1'b0;
`endif

    assign key_shifted = (key_q >> 1) | (KEY_W'(key_sin) << (KEY_W - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        state_d   = state_q;
        key_d     = key_q;
        key_cnt_d = key_cnt_q;
        flush     = 1'b0;
        unique case (state_q)
            KEY_LOAD: begin
                if (key_shift) begin
                    key_d     = key_shifted;
                    key_cnt_d = key_cnt_q + 1'b1;
                    if (key_cnt_q == CNT_W'(KEY_W - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Re-keying drops everything in flight; the key keeps shifting from its current value.
                if (key_shift) begin
                    key_d     = key_shifted;
                    key_cnt_d = '0;
                    state_d   = KEY_LOAD;
                    flush     = 1'b1;
                end
            end
            default: state_d = KEY_LOAD;
        endcase
    end

    assign key_ready = (state_q == RUN);

    // Carry d[j] is the parity of the key mismatches at every key position that folds onto bit j.
    always_comb begin
        corrupt = '0;
        for (int k = 0; k < KEY_W; k++) begin
            corrupt[k % WIDTH] = corrupt[k % WIDTH] ^ key_q[k] ^ KEY_POL[k];
        end
    end

    function automatic stage_t resolve_group(input stage_t x, input int unsigned grp,
                                             input logic [WIDTH-1:0] d);
        stage_t y;
        logic   p;
        logic   g;
        logic   c;
        y = x;
        c = x.carry;
        for (int unsigned i = 0; i < GROUP; i++) begin
            p = x.a[grp*GROUP + i] ^ x.b[grp*GROUP + i];
            g = x.a[grp*GROUP + i] & x.b[grp*GROUP + i];
            y.sum[grp*GROUP + i] = p ^ c;
            c = (g | (p & c)) ^ d[grp*GROUP + i];
        end
        y.carry = c;
        return y;
    endfunction

    always_comb begin
        vld_d = vld_q;
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s] = stage_q[s];
        end

        // A stage may load when it is empty or its successor moves; this collapses bubbles behind a stall.
        adv[STAGES-1] = !vld_q[STAGES-1] || out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv[s] = !vld_q[s] || adv[s+1];
        end

        in_ready = key_ready && adv[0];
        take     = in_valid && in_ready;

        src0       = '0;
        src0.a     = add1_i;
        src0.b     = add2_i;
        src0.carry = cin_bit;

        if (adv[0]) begin
            vld_d[0] = take;
            if (take) begin
                stage_d[0] = resolve_group(src0, 0, corrupt);
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            if (adv[s]) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    stage_d[s] = resolve_group(stage_q[s-1], unsigned'(s), corrupt);
                end
            end
        end

        if (flush) begin
            vld_d = '0;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result_o  = {stage_q[STAGES-1].carry, stage_q[STAGES-1].sum};

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= KEY_LOAD;
            key_q     <= '0;
            key_cnt_q <= '0;
            vld_q     <= '0;
            // NOTE: stage data is reset as well because result_o must read 0 out of reset.
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            key_cnt_q <= key_cnt_d;
            vld_q     <= vld_d;
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

endmodule
